// File: rtl/stupidrv.sv
// stupidrv -- single-issue, cache-less RV32I core.
//
// Every instruction executes in the cycle its word arrives on imem_data.
// Redirects become next_pc in that same cycle. Loads take two cycles:
// the first issues the read and holds the pc, and the second writes rd.
//
// Parameter RESET_PC : first fetch address after reset.
//
// Ports:
//   clock      : the single clock; all state updates on its rising edge
//   reset      : synchronous, active-low
//   stall      : freezes all core state while high
//   imem_addr  : fetch byte address, driven combinationally with next_pc
//   imem_data  : word at the previous cycle's imem_addr (that is, at pc)
//   dmem_valid : data access request this cycle
//   dmem_addr  : data byte address
//   dmem_wstrb : byte write enables; 0000 = read
//   dmem_wdata : lane-aligned store data
//   dmem_rdata : read word for the previous cycle's access
//
// Build option:
//   STUPIDRV_ILLEGAL_HALT_EN
//     When defined, an illegal instruction halts the core until reset.
//     Otherwise an illegal instruction executes as a NOP.
module stupidrv #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        dmem_valid,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  logic [31:0] r_pc;
  logic [31:0] r_rf [32];
  logic        r_ld_pend;
  logic [1:0]  r_ld_lo;

  logic [6:0]  w_op;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_pc4, w_ea, w_next_pc, w_wr_val;
  logic        w_wr_en, w_ld_issue, w_st_issue, w_illegal, w_run, w_halted;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0: r = alt ? (a - b) : (a + b);
      3'd1: r = a << b[4:0];
      3'd2: r = {31'd0, $signed(a) < $signed(b)};
      3'd3: r = {31'd0, a < b};
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = $unsigned($signed(a) >>> b[4:0]);
        else     r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      default: return a >= b;
    endcase
  endfunction

  // Pick the addressed byte/half out of the returned word and extend it.
  function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [31:0] word,
                                         input logic [1:0] lo);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign w_op  = imem_data[6:0];
  assign w_rd  = imem_data[11:7];
  assign w_f3  = imem_data[14:12];
  assign w_rs1 = imem_data[19:15];
  assign w_rs2 = imem_data[24:20];
  assign w_f7  = imem_data[31:25];

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

  assign w_imm_i = {{20{imem_data[31]}}, imem_data[31:20]};
  assign w_imm_s = {{20{imem_data[31]}}, imem_data[31:25], imem_data[11:7]};
  assign w_imm_b = {{20{imem_data[31]}}, imem_data[7], imem_data[30:25],
                    imem_data[11:8], 1'b0};
  assign w_imm_u = {imem_data[31:12], 12'd0};
  assign w_imm_j = {{12{imem_data[31]}}, imem_data[19:12], imem_data[20],
                    imem_data[30:21], 1'b0};

  assign w_pc4 = r_pc + 32'd4;
  assign w_ea  = w_rs1_val + ((w_op == OP_STORE) ? w_imm_s : w_imm_i);

  always_comb begin
    w_next_pc  = w_pc4;
    w_wr_en    = 1'b0;
    w_wr_val   = 32'd0;
    w_ld_issue = 1'b0;
    w_st_issue = 1'b0;
    w_illegal  = 1'b0;
    case (w_op)
      OP_LUI: begin
        w_wr_en  = 1'b1;
        w_wr_val = w_imm_u;
      end
      OP_AUIPC: begin
        w_wr_en  = 1'b1;
        w_wr_val = r_pc + w_imm_u;
      end
      OP_JAL: begin
        w_wr_en   = 1'b1;
        w_wr_val  = w_pc4;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: begin
        if (w_f3 != 3'd0) w_illegal = 1'b1;
        else begin
          w_wr_en   = 1'b1;
          w_wr_val  = w_pc4;
          w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
        end
      end
      OP_BR: begin
        if (w_f3 == 3'd2 || w_f3 == 3'd3) w_illegal = 1'b1;
        else if (br_taken(w_f3, w_rs1_val, w_rs2_val)) w_next_pc = r_pc + w_imm_b;
      end
      OP_LOAD: begin
        if (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7) w_illegal = 1'b1;
        else if (!r_ld_pend) begin
          // First cycle: issue the read and refetch the same word.
          w_ld_issue = 1'b1;
          w_next_pc  = r_pc;
        end else begin
          w_wr_en  = 1'b1;
          w_wr_val = ld_ext(w_f3, dmem_rdata, r_ld_lo);
        end
      end
      OP_STORE: begin
        if (w_f3 > 3'd2) w_illegal = 1'b1;
        else w_st_issue = 1'b1;
      end
      OP_IMM: begin
        if ((w_f3 == 3'd1 && w_f7 != 7'd0) ||
            (w_f3 == 3'd5 && w_f7 != 7'd0 && w_f7 != 7'h20)) w_illegal = 1'b1;
        else begin
          w_wr_en  = 1'b1;
          w_wr_val = alu(w_f3, (w_f3 == 3'd5) && w_f7[5], w_rs1_val, w_imm_i);
        end
      end
      OP_REG: begin
        if (w_f7 != 7'd0 && !(w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)))
          w_illegal = 1'b1;
        else begin
          w_wr_en  = 1'b1;
          w_wr_val = alu(w_f3, w_f7[5], w_rs1_val, w_rs2_val);
        end
      end
      OP_FENCE: begin
        if (w_f3 != 3'd0) w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
`ifdef STUPIDRV_ILLEGAL_HALT_EN
    if (w_illegal) w_next_pc = r_pc;
`endif
  end

  assign w_run = reset && !stall && !w_halted;

  assign imem_addr  = !reset ? RESET_PC : (w_run ? w_next_pc : r_pc);
  assign dmem_valid = w_run && (w_ld_issue || w_st_issue);
  assign dmem_addr  = w_ea;

  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = w_rs2_val;
    if (w_run && w_st_issue) begin
      case (w_f3)
        3'd0: begin
          dmem_wstrb = 4'b0001 << w_ea[1:0];
          dmem_wdata = {4{w_rs2_val[7:0]}};
        end
        3'd1: begin
          dmem_wstrb = 4'b0011 << w_ea[1:0];
          dmem_wdata = {2{w_rs2_val[15:0]}};
        end
        default: dmem_wstrb = 4'b1111;
      endcase
    end
  end

`ifdef STUPIDRV_ILLEGAL_HALT_EN
  logic r_halt;
  always_ff @(posedge clock) begin
    if (!reset) r_halt <= 1'b0;
    else if (w_run && w_illegal) r_halt <= 1'b1;
  end
  assign w_halted = r_halt;
`else
  assign w_halted = 1'b0;
`endif

  // ---- state update ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_ld_pend <= 1'b0;
    end else if (w_run) begin
      r_pc      <= w_next_pc;
      r_ld_pend <= w_ld_issue;
    end else if (stall) begin
      // The read data for a pending load lands while the core is frozen
      // and would be gone afterwards, so the load issues its read again.
      r_ld_pend <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_run && w_ld_issue) r_ld_lo <= w_ea[1:0];
  end

  always_ff @(posedge clock) begin
    if (w_run && w_wr_en && w_rd != 5'd0) r_rf[w_rd] <= w_wr_val;
  end
endmodule

// File: tb/tb_stupidrv.sv
module tb_stupidrv;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_valid;
  logic [3:0]  dmem_wstrb;

  always #5 clock = ~clock;

  stupidrv #(.RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memories: 1-cycle-latency instruction ROM and byte-addressed data RAM.
  logic [31:0] imem [0:255];
  bit   [7:0]  dmem [bit [31:0]];
  bit   [31:0] mem_a;

  function automatic bit [7:0] dbyte(input bit [31:0] a);
    return dmem.exists(a) ? dmem[a] : 8'd0;
  endfunction

  always @(posedge clock) begin
    imem_data <= imem[imem_addr[9:2]];
    if (dmem_valid) begin
      mem_a = {dmem_addr[31:2], 2'b00};
      dmem_rdata <= {dbyte(mem_a + 3), dbyte(mem_a + 2), dbyte(mem_a + 1), dbyte(mem_a)};
      for (int i = 0; i < 4; i++)
        if (dmem_wstrb[i]) dmem[mem_a + 32'(i)] = dmem_wdata[8*i +: 8];
    end
  end

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } st_t;
  st_t got_st[$];
  st_t exp_st[$];
  bit  mon_en = 1'b0;

  always @(negedge clock)
    if (mon_en && reset && dmem_valid && dmem_wstrb != 4'd0)
      got_st.push_back('{dmem_addr, dmem_wstrb, dmem_wdata});

  // Instruction encoders
  function automatic logic [31:0] e_i(input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] e_s(input logic [2:0] f3, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_b(input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] e_u(input logic [6:0] op, input logic [4:0] rd,
      input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] e_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [31:0] HALT_LOOP = 32'h0000_006F;  // JAL x0,0

  // Architectural reference model: one instruction per step, byte memory.
  logic [31:0] mx [32];
  bit   [7:0]  mm [bit [31:0]];
  int          m_steps;

  function automatic bit [7:0] mbyte(input bit [31:0] a);
    return mm.exists(a) ? mm[a] : 8'd0;
  endfunction

  task automatic model_run();
    logic [31:0] pc, npc, w, a, b, b2, res, ea, ii, si;
    logic [2:0]  f3;
    bit          wr, alt;
    int          n;
    pc = 0;
    m_steps = 0;
    mm.delete();
    exp_st.delete();
    for (int r = 0; r < 32; r++) mx[r] = 0;
    while (m_steps < 2000) begin
      w = imem[pc[9:2]];
      if (w == HALT_LOOP) break;
      m_steps++;
      f3  = w[14:12];
      a   = mx[w[19:15]];
      b   = mx[w[24:20]];
      ii  = {{20{w[31]}}, w[31:20]};
      si  = {{20{w[31]}}, w[31:25], w[11:7]};
      npc = pc + 4;
      wr  = 0;
      res = 0;
      case (w[6:0])
        7'h37: begin wr = 1; res = {w[31:12], 12'd0}; end
        7'h17: begin wr = 1; res = pc + {w[31:12], 12'd0}; end
        7'h6F: begin
          wr = 1; res = pc + 4;
          npc = pc + {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        end
        7'h67: begin wr = 1; res = pc + 4; npc = (a + ii) & 32'hFFFF_FFFE; end
        7'h63: begin
          bit t;
          case (f3)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd4: t = ($signed(a) < $signed(b));
            3'd5: t = ($signed(a) >= $signed(b));
            3'd6: t = (a < b);
            default: t = (a >= b);
          endcase
          if (t) npc = pc + {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        end
        7'h03: begin
          ea = a + ii; wr = 1;
          case (f3)
            3'd0: res = {{24{mbyte(ea)[7]}}, mbyte(ea)};
            3'd1: res = {{16{mbyte(ea + 1)[7]}}, mbyte(ea + 1), mbyte(ea)};
            3'd4: res = {24'd0, mbyte(ea)};
            3'd5: res = {16'd0, mbyte(ea + 1), mbyte(ea)};
            default: res = {mbyte(ea + 3), mbyte(ea + 2), mbyte(ea + 1), mbyte(ea)};
          endcase
        end
        7'h23: begin
          st_t e;
          ea = a + si;
          n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
          for (int k = 0; k < n; k++) mm[ea + 32'(k)] = b[8*k +: 8];
          e.a = ea;
          e.s = 4'((1 << n) - 1) << ea[1:0];
          e.d = (n == 1) ? {4{b[7:0]}} : (n == 2) ? {2{b[15:0]}} : b;
          exp_st.push_back(e);
        end
        7'h13, 7'h33: begin
          b2  = (w[6:0] == 7'h13) ? ii : b;
          alt = w[30] && (f3 == 3'd5 || (f3 == 3'd0 && w[6:0] == 7'h33));
          wr  = 1;
          case (f3)
            3'd0: res = alt ? a - b2 : a + b2;
            3'd1: res = a << b2[4:0];
            3'd2: res = ($signed(a) < $signed(b2)) ? 1 : 0;
            3'd3: res = (a < b2) ? 1 : 0;
            3'd4: res = a ^ b2;
            3'd5: begin
              if (alt) res = $signed(a) >>> b2[4:0];
              else     res = a >> b2[4:0];
            end
            3'd6: res = a | b2;
            default: res = a & b2;
          endcase
        end
        default: ;
      endcase
      if (wr && w[11:7] != 5'd0) mx[w[11:7]] = res;
      pc = npc;
    end
  endtask

  // Random legal program over x1..x7, ending in a register dump to 0x600.
  task automatic gen_prog();
    int p;
    logic [2:0] f3;
    logic [11:0] imm;
    for (int i = 0; i < 256; i++) imem[i] = HALT_LOOP;
    p = 0;
    for (int r = 1; r < 8; r++) begin
      imem[p] = e_u(7'h37, 5'(r), 20'($urandom)); p++;
      imem[p] = e_i(7'h13, 5'(r), 3'd0, 5'(r), 12'($urandom)); p++;
    end
    for (int k = 0; k < 30; k++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 6))
        0: imem[p] = e_r((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00,
                         5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)), f3,
                         5'($urandom_range(0, 7)));
        1: begin
          imm = 12'($urandom);
          if (f3 == 1) imm[11:5] = 7'h00;
          if (f3 == 5) imm[11:5] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
          imem[p] = e_i(7'h13, 5'($urandom_range(0, 7)), f3, 5'($urandom_range(1, 7)), imm);
        end
        2: begin
          f3 = 3'($urandom_range(0, 2));
          imm = 12'(32'h400 + 4 * $urandom_range(0, 15) +
                    (f3 == 0 ? $urandom_range(0, 3) : f3 == 1 ? 2 * $urandom_range(0, 1) : 0));
          imem[p] = e_s(f3, 5'($urandom_range(1, 7)), 5'd0, imm);
        end
        3: begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
          endcase
          imm = 12'(32'h400 + 4 * $urandom_range(0, 15) +
                    (f3[1:0] == 0 ? $urandom_range(0, 3) : f3[1:0] == 1 ? 2 * $urandom_range(0, 1) : 0));
          imem[p] = e_i(7'h03, 5'($urandom_range(1, 7)), f3, 5'd0, imm);
        end
        4: begin
          if (f3 == 2 || f3 == 3) f3 = 3'd0;
          imem[p] = e_b(f3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        $urandom_range(0, 1) == 1 ? 13'd8 : 13'd12);
        end
        5: imem[p] = e_u($urandom_range(0, 1) == 1 ? 7'h17 : 7'h37,
                         5'($urandom_range(1, 7)), 20'($urandom));
        default: imem[p] = $urandom_range(0, 1) == 1 ? e_j(5'($urandom_range(0, 7)), 21'd8)
                                                     : 32'h0FF0_000F;
      endcase
      p++;
    end
    for (int r = 1; r < 8; r++) begin
      imem[p] = e_s(3'd2, 5'(r), 5'd0, 12'(32'h600 + 4 * r)); p++;
    end
  endtask

  task automatic hold_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    stall = 1'b0;
    dmem.delete();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic run_dut(input bit use_stall, input int budget);
    logic [31:0] last_ia;
    got_st.delete();
    hold_reset();
    mon_en = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      last_ia = imem_addr;
      @(posedge clock); #1;
      if (use_stall && c == 12) begin
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          chk("stall_imem_addr", imem_addr, last_ia);
          chk("stall_dmem_valid", 32'(dmem_valid), 32'd0);
          @(posedge clock); #1;
        end
        stall = 1'b0;
      end else begin
        stall = use_stall && ($urandom_range(0, 3) == 0);
      end
    end
    stall = 1'b0;
    @(negedge clock);
    mon_en = 1'b0;
    chk("store_count", 32'(got_st.size()), 32'(exp_st.size()));
    for (int i = 0; i < exp_st.size(); i++)
      if (i < got_st.size()) begin
        chk("store_addr", got_st[i].a, exp_st[i].a);
        chk("store_strb", 32'(got_st[i].s), 32'(exp_st[i].s));
        chk("store_data", got_st[i].d, exp_st[i].d);
      end
  endtask

  initial begin
    // Reset held 3 cycles, directed program loaded meanwhile.
    for (int i = 0; i < 256; i++) imem[i] = HALT_LOOP;
    imem[0]  = e_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd5);       // ADDI x1,x0,5
    imem[1]  = e_u(7'h37, 5'd2, 20'h02000);              // LUI x2,0x02000
    imem[2]  = e_s(3'd2, 5'd1, 5'd2, 12'd0);             // SW x1,0(x2)
    imem[3]  = e_i(7'h13, 5'd1, 3'd0, 5'd0, 12'h0A5);    // ADDI x1,x0,0xA5
    imem[4]  = e_s(3'd0, 5'd1, 5'd0, 12'd1);             // SB x1,1(x0)
    imem[5]  = e_i(7'h03, 5'd3, 3'd0, 5'd0, 12'd1);      // LB x3,1(x0)
    imem[6]  = e_i(7'h03, 5'd4, 3'd4, 5'd0, 12'd1);      // LBU x4,1(x0)
    imem[7]  = e_i(7'h13, 5'd5, 3'd0, 5'd0, 12'h101);    // ADDI x5,x0,0x101
    imem[8]  = e_b(3'd0, 5'd0, 5'd0, 13'd16);            // BEQ x0,x0,+16
    imem[9]  = e_i(7'h13, 5'd4, 3'd0, 5'd0, 12'd1);
    imem[10] = e_i(7'h13, 5'd4, 3'd0, 5'd0, 12'd2);
    imem[11] = e_i(7'h13, 5'd4, 3'd0, 5'd0, 12'd3);
    imem[12] = e_i(7'h67, 5'd1, 3'd0, 5'd5, 12'd0);      // JALR x1,x5,0
    imem[64] = e_s(3'd2, 5'd3, 5'd0, 12'h040);           // SW x3,0x40(x0)
    imem[65] = e_s(3'd2, 5'd4, 5'd0, 12'h044);           // SW x4,0x44(x0)
    imem[66] = e_s(3'd2, 5'd1, 5'd0, 12'h048);           // SW x1,0x48(x0)
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_dmem_valid", 32'(dmem_valid), 32'd0);
      chk("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    end
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock); chk("first_fetch", imem_addr, 32'h4);
    @(negedge clock); chk("lui_next", imem_addr, 32'h8);
    @(negedge clock);
    chk("sw_valid", 32'(dmem_valid), 32'd1);
    chk("sw_addr", dmem_addr, 32'h0200_0000);
    chk("sw_wstrb", 32'(dmem_wstrb), 32'hF);
    chk("sw_wdata", dmem_wdata, 32'd5);
    @(negedge clock); chk("idle_valid", 32'(dmem_valid), 32'd0);
    @(negedge clock);
    chk("sb_addr", dmem_addr, 32'h1);
    chk("sb_wstrb", 32'(dmem_wstrb), 32'h2);
    chk("sb_lane", 32'(dmem_wdata[15:8]), 32'hA5);
    @(negedge clock);
    chk("lb_issue_valid", 32'(dmem_valid), 32'd1);
    chk("lb_issue_wstrb", 32'(dmem_wstrb), 32'd0);
    chk("lb_hold_pc", imem_addr, 32'h14);
    @(negedge clock);
    chk("lb_done_valid", 32'(dmem_valid), 32'd0);
    chk("lb_done_pc", imem_addr, 32'h18);
    repeat (3) @(negedge clock);
    @(negedge clock); chk("beq_redirect", imem_addr, 32'h30);
    @(negedge clock); chk("jalr_target", imem_addr, 32'h100);
    @(negedge clock); chk("lb_result", dmem_wdata, 32'hFFFF_FFA5);
    @(negedge clock); chk("lbu_result", dmem_wdata, 32'h0000_00A5);
    @(negedge clock); chk("jalr_link", dmem_wdata, 32'h34);

    // Illegal word at 0x8
    for (int i = 0; i < 256; i++) imem[i] = HALT_LOOP;
    imem[0] = e_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd1);
    imem[1] = e_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd2);
    imem[2] = 32'h0000_0000;
    imem[3] = e_s(3'd2, 5'd1, 5'd0, 12'h080);
    hold_reset();
    repeat (2) @(negedge clock);
    @(negedge clock);
`ifdef STUPIDRV_ILLEGAL_HALT_EN
    chk("illegal_pc", imem_addr, 32'h8);
    @(negedge clock);
    chk("halted_pc", imem_addr, 32'h8);
    chk("halted_valid", 32'(dmem_valid), 32'd0);
`else
    chk("illegal_pc", imem_addr, 32'hC);
    @(negedge clock);
    chk("after_illegal_pc", imem_addr, 32'h10);
    chk("after_illegal_sw", dmem_wdata, 32'd2);
`endif

    // Random programs, each run without and with stalls.
    for (int s = 0; s < 3; s++) begin
      gen_prog();
      model_run();
      run_dut(1'b0, 2 * m_steps + 20);
      run_dut(1'b1, 3 * m_steps + 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
